hdlc_protocol_checker: RTL
==========================

Name: hdlc_protocol_checker

Overview:
Synthesizable, parametrised HDLC protocol checker. It watches the Rx serial line, the Tx serial line and the HDLC controller status strobes, and checks four rules with its own logic: flag-detect latency, abort signalling, the transmitted abort pattern, and Tx idle-high. Each rule drives a per-cycle error pulse and a saturating error counter. It sits beside the HDLC controller in the bench and can also be instantiated in emulation builds.

Parameters:
FLAG_LAT, 2, cycles from the last flag bit sampled on Rx to the required Rx_FlagDetect (1..8)
ABORT_LAT, 1, cycles from (Rx_AbortDetect && Rx_ValidFrame) to the required Rx_AbortSignal (1..8)
TX_ABORT_DLY, 4, cycles from the Tx abort trigger to the first abort-pattern bit on Tx (1..15)
IDLE_CYCLES, 10, consecutive cycles of Tx_ValidFrame low after which Tx must be high (1..255)
CNT_W, 16, width of each error counter

Ports:
Clk  in  1  clock
Rst  in  1  synchronous reset, active high
En  in  1  enables launching new checks; checks already in flight always complete
Clear  in  1  synchronous clear of all error counters
Rx  in  1  Rx serial line
Rx_FlagDetect  in  1  DUT flag-detect strobe
Rx_ValidFrame  in  1  DUT Rx valid frame
Rx_AbortDetect  in  1  DUT abort-detect strobe
Rx_AbortSignal  in  1  DUT abort signal
Tx  in  1  Tx serial line
Tx_ValidFrame  in  1  DUT Tx valid frame
Tx_AbortFrame  in  1  abort request to the DUT
ErrVec  out  4  one-cycle error pulses, registered: [0] flag, [1] abort signal, [2] Tx abort pattern, [3] idle
ErrCntFlag, ErrCntAbort, ErrCntTxAbort, ErrCntIdle  out  CNT_W each  saturating error counters
FirstErrValid  out  1  first-error capture valid (optional feature)
FirstErrId  out  2  index of the first failing rule (optional feature)
FirstErrCycle  out  32  cycle stamp of the first error (optional feature)

Behaviour:
- Reset values: Rx shift register all ones, which prevents a false flag match; delay lines 0; Tx FSM in IDLE; idle counter 0; all outputs 0.
- Flag check:
  - An 8-bit shift register samples Rx every cycle.
  - A match is the last 8 samples equal to 0,1,1,1,1,1,1,0 in time order. The match cycle is the cycle in which the closing 0 is sampled.
  - When a match occurs with En=1, a 1 enters an FLAG_LAT-deep delay line.
  - When that 1 emerges, Rx_FlagDetect is sampled in the same cycle; a 0 raises ErrVec[0] on the next cycle.
  - Back-to-back flags that share a 0 are checked independently.
- Abort check: (Rx_AbortDetect && Rx_ValidFrame && En) enters an ABORT_LAT-deep delay line. When it emerges, Rx_AbortSignal must be 1; otherwise ErrVec[1] pulses.
- Tx abort check, FSM with states IDLE, WAIT, ZERO, ONES:
  - IDLE -> WAIT on the rising edge of (Tx_ValidFrame && Tx_AbortFrame) with En=1. The wait counter loads TX_ABORT_DLY-1.
  - WAIT -> ZERO when the counter reaches 0. The trigger cycle plus TX_ABORT_DLY equals the ZERO cycle.
  - ZERO: Tx must be 0. Pass -> ONES with the count loaded to 7. Fail -> ErrVec[2] and return to IDLE.
  - ONES: Tx must be 1 for 7 consecutive cycles, then IDLE. Any 0 -> ErrVec[2] and return to IDLE.
  - A new trigger while the FSM is not in IDLE is ignored.
- Idle check:
  - The idle counter increments while Tx_ValidFrame=0 and saturates at IDLE_CYCLES. Tx_ValidFrame=1 resets it to 0.
  - Every cycle in which the counter value after update equals IDLE_CYCLES and Tx=0 raises ErrVec[3]. The check applies only when En=1.
- Counters:
  - Each counter increments on its ErrVec bit and saturates at 2^CNT_W-1 with no wrap.
  - When Clear and an error occur in the same cycle, Clear wins (counter = 0); the ErrVec pulse still appears.
- Rst mid-operation: all in-flight checks are dropped, and no errors are reported for checks that started before reset.

Optional Feature:
HDLC_CHK_FIRST_ERR_EN:
- Defined:
  - A free-running 32-bit cycle counter runs from 0 after Rst.
  - On the first ErrVec pulse after Rst or Clear, FirstErrValid is set to 1, FirstErrId is loaded with the lowest set ErrVec index, and FirstErrCycle is loaded with the counter value. All three then hold until the next Rst or Clear.
- Not defined: the three ports are tied to 0 and no cycle counter is built.

Test Plan:
- Rx = 1 idle, then 0,1,1,1,1,1,1,0, with the DUT model pulsing Rx_FlagDetect exactly 2 cycles after the closing 0 -> ErrVec=0 and ErrCntFlag=0. Delay the pulse to 3 cycles -> one ErrVec[0] pulse and ErrCntFlag=1.
- Rx_ValidFrame=1 with a one-cycle Rx_AbortDetect and Rx_AbortSignal high on the next cycle -> no error. Hold Rx_AbortSignal low -> ErrCntAbort=1.
- Tx_ValidFrame=1 and Tx_AbortFrame rising at cycle t, with Tx=0 at t+4 and Tx=1 at t+5..t+11 -> no error. Force Tx=0 at t+8 -> ErrCntTxAbort=1 and the FSM returns to IDLE.
- Tx_ValidFrame low for 12 cycles with Tx=0 on cycles 9 and 10 -> exactly one ErrVec[3] pulse (cycle 10) and ErrCntIdle=1.
- CNT_W=2 with 5 forced flag errors -> ErrCntFlag saturates at 3. Assert Clear in the same cycle as a 6th error -> counter = 0 and the ErrVec[0] pulse is still seen.
- With HDLC_CHK_FIRST_ERR_EN defined, an idle error at cycle 40 followed by a flag error at cycle 55 -> FirstErrValid=1, FirstErrId=3, FirstErrCycle=40, and these values hold after cycle 55. Rst mid-abort-check -> no error reported.

Source files
------------

// File: rtl/hdlc_protocol_checker.sv
// HDLC protocol checker: flag-detect latency, abort signalling, Tx abort pattern and Tx idle-high rules.
// Optional first-error capture is built when HDLC_CHK_FIRST_ERR_EN is defined.
module hdlc_protocol_checker #(
  parameter int FLAG_LAT     = 2,
  parameter int ABORT_LAT    = 1,
  parameter int TX_ABORT_DLY = 4,
  parameter int IDLE_CYCLES  = 10,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Clear,
  input  logic             Rx,
  input  logic             Rx_FlagDetect,
  input  logic             Rx_ValidFrame,
  input  logic             Rx_AbortDetect,
  input  logic             Rx_AbortSignal,
  input  logic             Tx,
  input  logic             Tx_ValidFrame,
  input  logic             Tx_AbortFrame,
  output logic [3:0]       ErrVec,
  output logic [CNT_W-1:0] ErrCntFlag,
  output logic [CNT_W-1:0] ErrCntAbort,
  output logic [CNT_W-1:0] ErrCntTxAbort,
  output logic [CNT_W-1:0] ErrCntIdle,
  output logic             FirstErrValid,
  output logic [1:0]       FirstErrId,
  output logic [31:0]      FirstErrCycle
);

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_ZERO, TX_ONES} tx_state_e;

  localparam logic [7:0]       FLAG_PAT = 8'b0111_1110;
  localparam logic [7:0]       IDLE_MAX = 8'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && v != CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  logic [7:0]           rx_sr_q, rx_sr_d;
  logic                 flag_match;
  logic [FLAG_LAT-1:0]  flag_dl_q, flag_dl_d;
  logic [ABORT_LAT-1:0] abort_dl_q, abort_dl_d;
  logic [7:0]           idle_cnt_q, idle_cnt_d;
  tx_state_e            tx_state_q;
  logic [3:0]           tx_cnt_q;
  logic                 tx_trig_q;
  logic                 tx_trig, tx_rise, tx_err;
  logic [3:0]           err_d;
  logic [3:0]           err_vec_q;
  logic [CNT_W-1:0]     err_cnt_q [4];

  // The closing 0 of a flag is matched in the cycle it arrives, before it is shifted in.
  always_comb begin
    rx_sr_d       = {rx_sr_q[6:0], Rx};
    flag_match    = (rx_sr_d == FLAG_PAT);
    flag_dl_d     = flag_dl_q << 1;
    flag_dl_d[0]  = flag_match & En;
    abort_dl_d    = abort_dl_q << 1;
    abort_dl_d[0] = Rx_AbortDetect & Rx_ValidFrame & En;
  end

  always_comb begin
    if (Tx_ValidFrame)
      idle_cnt_d = 8'd0;
    else if (idle_cnt_q == IDLE_MAX)
      idle_cnt_d = idle_cnt_q;
    else
      idle_cnt_d = idle_cnt_q + 8'd1;
  end

  assign tx_trig = Tx_ValidFrame & Tx_AbortFrame;
  assign tx_rise = tx_trig & ~tx_trig_q & En;
  assign tx_err  = ((tx_state_q == TX_ZERO) && Tx) || ((tx_state_q == TX_ONES) && !Tx);

  assign err_d = {En & (idle_cnt_d == IDLE_MAX) & ~Tx,
                  tx_err,
                  abort_dl_q[ABORT_LAT-1] & ~Rx_AbortSignal,
                  flag_dl_q[FLAG_LAT-1] & ~Rx_FlagDetect};

  // Tx abort-pattern FSM: the wait counter hits 0 exactly as the FSM enters ZERO.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 4'd0;
      tx_trig_q  <= 1'b0;
    end else begin
      tx_trig_q <= tx_trig;
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_rise) begin
            tx_cnt_q <= 4'(TX_ABORT_DLY - 1);
            if (TX_ABORT_DLY == 1) tx_state_q <= TX_ZERO;
            else                   tx_state_q <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          tx_cnt_q <= tx_cnt_q - 4'd1;
          if (tx_cnt_q == 4'd1) tx_state_q <= TX_ZERO;
        end
        TX_ZERO: begin
          if (tx_err) begin
            tx_state_q <= TX_IDLE;
          end else begin
            tx_state_q <= TX_ONES;
            tx_cnt_q   <= 4'd7;
          end
        end
        TX_ONES: begin
          tx_cnt_q <= tx_cnt_q - 4'd1;
          if (tx_err || tx_cnt_q == 4'd1) tx_state_q <= TX_IDLE;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_sr_q    <= 8'hFF;
      flag_dl_q  <= '0;
      abort_dl_q <= '0;
      idle_cnt_q <= 8'd0;
      err_vec_q  <= 4'd0;
    end else begin
      rx_sr_q    <= rx_sr_d;
      flag_dl_q  <= flag_dl_d;
      abort_dl_q <= abort_dl_d;
      idle_cnt_q <= idle_cnt_d;
      err_vec_q  <= err_d;
    end
  end

  // Clear beats a same-cycle error; the ErrVec pulse is unaffected.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (Rst || Clear) err_cnt_q[i] <= '0;
      else              err_cnt_q[i] <= sat_inc(err_cnt_q[i], err_d[i]);
    end
  end

  assign ErrVec        = err_vec_q;
  assign ErrCntFlag    = err_cnt_q[0];
  assign ErrCntAbort   = err_cnt_q[1];
  assign ErrCntTxAbort = err_cnt_q[2];
  assign ErrCntIdle    = err_cnt_q[3];

`ifdef HDLC_CHK_FIRST_ERR_EN
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (v[i]) idx = 2'(i);
    return idx;
  endfunction

  logic [31:0] cyc_q;
  logic        first_vld_q;
  logic [1:0]  first_id_q;
  logic [31:0] first_cyc_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cyc_q       <= 32'd0;
      first_vld_q <= 1'b0;
      first_id_q  <= 2'd0;
      first_cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (Clear) begin
        first_vld_q <= 1'b0;
        first_id_q  <= 2'd0;
        first_cyc_q <= 32'd0;
      end else if (!first_vld_q && err_vec_q != 4'd0) begin
        first_vld_q <= 1'b1;
        first_id_q  <= lowest_idx(err_vec_q);
        first_cyc_q <= cyc_q;
      end
    end
  end

  assign FirstErrValid = first_vld_q;
  assign FirstErrId    = first_id_q;
  assign FirstErrCycle = first_cyc_q;
`else
  assign FirstErrValid = 1'b0;
  assign FirstErrId    = 2'd0;
  assign FirstErrCycle = 32'd0;
`endif

endmodule
